// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared sizing defaults and the hardwired zero-register address.
package register_file_mp_pkg;
  localparam int DEF_WORD_SIZE = 64;
  localparam int DEF_REG_ADDR_SIZE = 4;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/register_file_mp_reg_scoreboard.sv
// reg_scoreboard: per-register busy bitmap with reserve (set), write-back (clear) and read-port lookup.
module reg_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int NUM_READ = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic set_en,
  input  logic [REG_ADDR_SIZE-1:0] set_addr,
  input  logic [2**REG_ADDR_SIZE-1:0] clr,
  input  logic [NUM_READ*REG_ADDR_SIZE-1:0] look_addr,
  output logic [NUM_READ-1:0] look_cur,
  output logic [NUM_READ-1:0] look_nxt
);
  localparam int N = 2**REG_ADDR_SIZE;
  localparam int A = REG_ADDR_SIZE;
  logic [N-1:0] busy, busy_nxt, set;
  assign set = N'(set_en) << set_addr;
  // set after clear so a same-cycle reserve survives the write-back
  assign busy_nxt = ((busy & ~clr) | set) & ~(N'(1) << ZERO_REG);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else if (en) busy <= busy_nxt;
  for (genvar i = 0; i < NUM_READ; i++) begin : g_look
    assign look_cur[i] = busy[look_addr[i*A +: A]];
    assign look_nxt[i] = busy_nxt[look_addr[i*A +: A]];
  end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with hardwired zero register, optional write forwarding and busy scoreboard.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
  parameter int NUM_READ = 2,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [NUM_WRITE-1:0] we,
  input  logic [NUM_WRITE*REG_ADDR_SIZE-1:0] waddr,
  input  logic [NUM_WRITE*WORD_SIZE-1:0] wdata,
  input  logic [NUM_READ*REG_ADDR_SIZE-1:0] raddr,
  output logic [NUM_READ*WORD_SIZE-1:0] rdata,
  output logic [NUM_READ-1:0] rbusy,
  input  logic rsv_en,
  input  logic [REG_ADDR_SIZE-1:0] rsv_addr
);
  localparam int N = 2**REG_ADDR_SIZE;
  localparam int A = REG_ADDR_SIZE;
  localparam int W = WORD_SIZE;
  logic [N-1:0][W-1:0] cur, nxt;
  logic [N-1:0] clr;
  logic [NUM_READ-1:0] busy_cur, busy_nxt;
  for (genvar r = 0; r < N; r++) begin : g_reg
    logic hit;
    logic [W-1:0] val, q;
    // later ports overwrite earlier ones, so the highest-numbered writer wins
    always_comb begin
      hit = 1'b0;
      val = q;
      for (int k = 0; k < NUM_WRITE; k++)
        if (we[k] && waddr[k*A +: A] == A'(r)) begin
          hit = 1'b1;
          val = wdata[k*W +: W];
        end
    end
    if (r == ZERO_REG) begin : g_zero
      assign q = '0;
    end else begin : g_live
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en && hit) q <= val;
    end
    assign cur[r] = q;
    assign nxt[r] = (r == ZERO_REG) ? '0 : val;
    assign clr[r] = hit;
  end
  reg_scoreboard #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .NUM_READ(NUM_READ)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .set_en(rsv_en),
    .set_addr(rsv_addr),
    .clr(clr),
    .look_addr(raddr),
    .look_cur(busy_cur),
    .look_nxt(busy_nxt)
  );
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [A-1:0] a;
    logic [W-1:0] d;
    logic b;
    assign a = raddr[i*A +: A];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d <= '0;
        b <= 1'b0;
      end else if (en) begin
        d <= (BYPASS != 0) ? nxt[a] : cur[a];
        b <= (BYPASS != 0) ? busy_nxt[i] : busy_cur[i];
      end
    assign rdata[i*W +: W] = d;
    assign rbusy[i] = b;
  end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 64, bits per register.
REQ-002 SHALL have parameter REG_ADDR_SIZE, default 4, giving 2**REG_ADDR_SIZE registers.
REQ-003 SHALL have parameter NUM_READ, default 2, read port count (1..4).
REQ-004 SHALL have parameter NUM_WRITE, default 2, write port count (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port en  input  1  global enable; low blocks writes, reserves and read updates.
REQ-009 SHALL have port we  input  NUM_WRITE  per-write-port enable.
REQ-010 SHALL have port waddr  input  NUM_WRITE*REG_ADDR_SIZE  packed write addresses, port 0 in LSBs.
REQ-011 SHALL have port wdata  input  NUM_WRITE*WORD_SIZE  packed write data.
REQ-012 SHALL have port raddr  input  NUM_READ*REG_ADDR_SIZE  packed read addresses.
REQ-013 SHALL have port rdata  output  NUM_READ*WORD_SIZE  packed registered read data.
REQ-014 SHALL have port rbusy  output  NUM_READ  registered scoreboard busy flag for each read address.
REQ-015 SHALL have port rsv_en  input  1  reserve (mark busy) request.
REQ-016 SHALL have port rsv_addr  input  REG_ADDR_SIZE  register to reserve.

Function
REQ-017 SHALL hold register 0 at zero permanently; writes and reserves to address 0 ignored; rbusy for address 0 always 0.
REQ-018 SHALL, on rising clk with en=1, write wdata[k] to waddr[k] for every k with we[k]=1.
REQ-019 SHALL, when two write ports target the same nonzero address in one cycle, store the higher-numbered port's data.
REQ-020 SHALL register rdata[i] and rbusy[i] on rising clk with en=1; read latency exactly 1 cycle from raddr.
REQ-021 SHALL, with BYPASS=1, return in rdata[i] the data being written this cycle when raddr[i] matches an active write address (priority per REQ-019).
REQ-022 SHALL, with BYPASS=0, return the pre-write register contents for a same-cycle address match.
REQ-023 SHALL set busy[rsv_addr] on rising clk when en=1 and rsv_en=1.
REQ-024 SHALL clear busy[waddr[k]] for each active write with en=1.
REQ-025 SHALL, for reserve and write to the same address in one cycle, store the write data and leave busy set (reserve wins).
REQ-026 SHALL compute rbusy[i] from post-update busy state when BYPASS=1, pre-update state when BYPASS=0.
REQ-027 SHALL, with en=0, ignore we and rsv_en and hold rdata/rbusy at previous values.
REQ-028 SHALL make all arithmetic/width handling unsigned with no truncation of WORD_SIZE data.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear all registers, all busy bits, rdata and rbusy to zero.
REQ-030 SHALL resume normal operation on the first rising clk after rst_n deasserts; operations in flight at assertion are discarded.

Structure
REQ-031 SHALL place default WORD_SIZE/REG_ADDR_SIZE constants and the zero-register address constant in the shared computer package.
REQ-032 SHALL implement the busy bitmap as sub-module reg_scoreboard (set/clear/lookup), instanced once.
REQ-033 SHALL generate read ports and write-merge logic with generate loops, no fixed port counts in RTL.

Verification
REQ-034 SHALL cover: reset, write 0xDEAD to r5 via port0, read r5 next cycle -> rdata=0xDEAD after 1 cycle, rbusy=0.
REQ-035 SHALL cover: both ports write r3 (0x11 port0, 0x22 port1) same cycle -> later read r3 = 0x22.
REQ-036 SHALL cover: write r7=0x55 while reading r7, BYPASS=1 -> rdata=0x55 next edge; BYPASS=0 -> old value.
REQ-037 SHALL cover: reserve r4, read r4 -> rbusy=1; write r4=0x9 -> rbusy=0, rdata=0x9; reserve+write r4 same cycle -> rbusy stays 1.
REQ-038 SHALL cover: write r0=0xFFFF and reserve r0 -> read r0 returns 0, rbusy=0.
REQ-039 SHALL cover: en=0 with we=1 to r2 -> r2 unchanged, outputs held; rst_n pulsed mid-operation -> all outputs 0 immediately.
